handshake_rx_responder: RTL
===========================

// Module: handshake_rx_responder
// PURPOSE
//  Receive-side endpoint of the 4-phase req/ack CDC handshake, in the rd_clk domain.
//  Synchronises the writer's level wr_req and captures the quasi-static wr_data bus.
//  Presents each word downstream on a valid/ready interface; returns level rd_ack to the writer domain.
//  One word in flight; the writer may raise wr_req again only after it sees rd_ack low.
// PARAMETERS
//  DATA_WIDTH   12  width of wr_data / rd_data
//  SYNC_STAGES  2   flops in the wr_req synchroniser; legal values >= 2
// PORTS
//  rd_clk        in   1           receive-domain clock; all state on posedge
//  rd_reset      in   1           asynchronous, active-low reset
//  wr_req        in   1           request level from writer domain (asynchronous)
//  wr_data       in   DATA_WIDTH  writer data; stable while wr_req high; never synchronised
//  rd_ack        out  1           ack level back to writer domain; driven from a flop
//  rd_data       out  DATA_WIDTH  captured word
//  rd_valid      out  1           rd_data holds an unconsumed word
//  rd_ready      in   1           downstream accepts the word when rd_valid && rd_ready
//  rd_busy       out  1           FSM not in IDLE
//  rd_proto_err  out  1           sticky: wr_req withdrawn before ack
// BEHAVIOUR
//  Reset (async assert, sync release): rd_ack=0, rd_valid=0, rd_data=0, rd_busy=0, rd_proto_err=0.
//  Reset also clears the synchroniser chain and puts the FSM in IDLE.
//  req_s = last stage of the SYNC_STAGES chain. wr_data is sampled only on an edge where req_s=1.
//  FSM, default build:
//   IDLE: req_s=1 -> rd_data<=wr_data, rd_valid<=1, go HOLD.
//   HOLD: rd_valid && rd_ready -> rd_valid<=0, rd_ack<=1, go ACKD.
//         req_s=0 in HOLD -> rd_proto_err<=1; word still delivered, ack still raised.
//   ACKD: req_s=0 -> rd_ack<=0, go IDLE.
//  Latency (default build):
//   wr_req rise -> rd_valid high: SYNC_STAGES+1 rd_clk edges.
//   Accept edge -> rd_ack high: 1 edge.
//   wr_req fall -> rd_ack low: SYNC_STAGES+1 edges.
//  rd_data and rd_valid are stable while rd_valid && !rd_ready; no word is dropped or duplicated.
//  req_s stays high in ACKD: hold rd_ack, no new capture. Capture happens only from IDLE.
//  Reset mid-transfer: in-flight word is discarded and rd_ack drops.
//   If wr_req is still high after release, that word is captured once, as a new request.
//  rd_proto_err clears only on reset.
// CONFIGURATION
//  HS_RX_SKID_EN undefined: default FSM above; ack waits for downstream acceptance.
//  HS_RX_SKID_EN defined: rd_data/rd_valid become an independent output register.
//   IDLE: req_s=1 && (!rd_valid || rd_ready) -> capture, rd_valid<=1, rd_ack<=1 on the same edge, go ACKD.
//   HOLD is unused.
//   rd_valid clears on rd_valid && rd_ready in any state.
//   Latency: wr_req rise -> rd_ack high: SYNC_STAGES+1 edges.
//   req_s=1 in IDLE while the word is held and rd_ready=0 -> wait; wr_data is not sampled.
//   rd_proto_err is tied 0.
// TESTING  (DATA_WIDTH=12, SYNC_STAGES=2)
//  1. rd_reset=0 with wr_req=1, wr_data=12'hFFF -> rd_ack=0, rd_valid=0, rd_data=12'h000, rd_busy=0.
//  2. wr_data=12'hA5C, raise wr_req, rd_ready=1 -> rd_valid=1 with rd_data=12'hA5C on the 3rd edge.
//     Then rd_ack=1 on the next edge. Drop wr_req -> rd_ack=0 on the 3rd edge after, rd_busy=0.
//  3. rd_ready=0 for 10 cycles with word 12'h3C3 held -> rd_data/rd_valid stable, rd_ack=0.
//     Raise rd_ready -> rd_ack=1 on the next edge.
//  4. Words 12'h001, 12'h7FF, 12'hFFF, each sent after rd_ack low -> received in order, exactly once, rd_proto_err=0.
//  5. Assert rd_reset in ACKD with wr_req=1, wr_data=12'h123 -> all outputs clear at once.
//     After release: 12'h123 delivered exactly once.
//  6. Drop wr_req in HOLD -> rd_proto_err=1 and stays 1. Repeat with HS_RX_SKID_EN:
//     rd_ready=0 -> rd_ack rises on the same edge as rd_valid; 2nd request waits until rd_ready.

Source files
------------

// File: rtl/handshake_rx_responder.sv
// handshake_rx_responder
//
// Receive-side endpoint of a 4-phase req/ack CDC handshake, living in the
// rd_clk domain. The writer's request level is passed through a synchroniser
// chain. The writer's data bus is held quasi-static while the request is high,
// so it is captured directly and is never synchronised. Each captured word is
// offered downstream on a valid/ready interface. The ack level goes back to
// the writer and is always driven straight from a flop.
//
// Build option (macro HS_RX_SKID_EN):
//   undefined : the ack is raised only after downstream has accepted the word
//               (IDLE -> HOLD -> ACKD).
//   defined   : rd_data/rd_valid act as an independent output register. The
//               ack is raised on the same edge as the capture (IDLE -> ACKD).
//               rd_proto_err is tied low.
//
// Parameters
//   DATA_WIDTH   width of wr_data / rd_data
//   SYNC_STAGES  flops in the wr_req synchroniser (>= 2)
//
// Ports
//   rd_clk        in   receive-domain clock, all state on posedge
//   rd_reset      in   asynchronous active-low reset
//   wr_req        in   request level from the writer domain (asynchronous)
//   wr_data       in   writer data, stable while wr_req is high
//   rd_ack        out  ack level back to the writer domain
//   rd_data       out  captured word
//   rd_valid      out  rd_data holds an unconsumed word
//   rd_ready      in   downstream accepts the word when rd_valid && rd_ready
//   rd_busy       out  FSM not idle
//   rd_proto_err  out  sticky: wr_req withdrawn before the ack was given
module handshake_rx_responder #(
    parameter int unsigned DATA_WIDTH  = 12,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  rd_clk,
    input  logic                  rd_reset,
    input  logic                  wr_req,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_ack,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_busy,
    output logic                  rd_proto_err
);

    typedef enum logic [1:0] {
        StIdle,
        StHold,
        StAckd
    } state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ack_q, ack_d;
    logic                    err_q, err_d;
    logic                    req_s;

    // Request synchroniser; only the last stage is used by the FSM.
    always_ff @(posedge rd_clk or negedge rd_reset) begin
        if (!rd_reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], wr_req};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge rd_clk or negedge rd_reset) begin
        if (!rd_reset) begin
            state_q <= StIdle;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

`ifdef HS_RX_SKID_EN
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        err_d   = 1'b0;

        // The output register drains independently of the handshake FSM.
        if (valid_q && rd_ready) begin
            valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                // Capture only when the output slot is free or being freed.
                // Otherwise wr_data is left unsampled and the writer waits.
                if (req_s && (!valid_q || rd_ready)) begin
                    data_d  = wr_data;
                    valid_d = 1'b1;
                    ack_d   = 1'b1;
                    state_d = StAckd;
                end
            end
            StAckd: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end
`else
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (req_s) begin
                    data_d  = wr_data;
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                // A withdrawn request is flagged, but the word already
                // captured is still delivered and acknowledged.
                if (!req_s) begin
                    err_d = 1'b1;
                end
                if (valid_q && rd_ready) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = StAckd;
                end
            end
            StAckd: begin
                // A request still high here is the one already acknowledged.
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end
`endif

    assign rd_ack       = ack_q;
    assign rd_data      = data_q;
    assign rd_valid     = valid_q;
    assign rd_busy      = (state_q != StIdle);
    assign rd_proto_err = err_q;

endmodule
